// File: rtl/cmp_rr_arbiter.sv
// Round-robin front end that time-shares one unsigned W-bit magnitude comparator
// between N_REQ requesters; captured operands, held response with ready/valid.
module cmp_rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] a_in,
  input  logic [N_REQ*W-1:0] b_in,
  output logic [N_REQ-1:0]   gnt,
  output logic               busy,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [ID_W-1:0]    rsp_id,
  output logic               rsp_eq,
  output logic               rsp_gt,
  output logic               rsp_sm
);

  typedef enum logic [1:0] {S_IDLE, S_CMP, S_RESP} state_t;

  state_t             r_state, w_next;
  logic [ID_W-1:0]    r_ptr, r_id, w_win, w_ptr_nxt;
  logic [W-1:0]       r_a, r_b;
  logic [N_REQ-1:0]   r_gnt;
  logic               r_valid, r_eq, r_gt, r_sm;
  logic [ID_W-1:0]    r_rsp_id;

  // Scan from the highest offset down so the lowest offset from p wins.
  function automatic logic [ID_W-1:0] f_pick(input logic [N_REQ-1:0] v,
                                             input logic [ID_W-1:0]  p);
    int idx;
    f_pick = p;
    for (int k = N_REQ-1; k >= 0; k--) begin
      idx = int'(p) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (v[idx[ID_W-1:0]]) f_pick = idx[ID_W-1:0];
    end
  endfunction

  assign w_win = f_pick(req, r_ptr);
  // Explicit wrap so non-power-of-2 N_REQ never lands on an unused index.
  assign w_ptr_nxt = (r_id == ID_W'(N_REQ-1)) ? '0 : r_id + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (|req)     w_next = S_CMP;
      S_CMP:                 w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default:               w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr    <= '0;
      r_id     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_gnt    <= '0;
      r_valid  <= 1'b0;
      r_rsp_id <= '0;
      r_eq     <= 1'b0;
      r_gt     <= 1'b0;
      r_sm     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_a   <= a_in[int'(w_win)*W +: W];
            r_b   <= b_in[int'(w_win)*W +: W];
            r_id  <= w_win;
            r_gnt <= N_REQ'(1) << w_win;
          end else begin
            r_gnt <= '0;
          end
        end
        S_CMP: begin
          r_gnt    <= '0;
          r_eq     <= (r_a == r_b);
          r_gt     <= (r_a >  r_b);
          r_sm     <= (r_a <  r_b);
          r_rsp_id <= r_id;
          r_valid  <= 1'b1;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_valid <= 1'b0;
            r_ptr   <= w_ptr_nxt;
          end
        end
        default: r_gnt <= '0;
      endcase
    end
  end

  always_comb begin
    busy      = (r_state != S_IDLE);
    gnt       = r_gnt;
    rsp_valid = r_valid;
    rsp_id    = r_rsp_id;
    rsp_eq    = r_eq;
    rsp_gt    = r_gt;
    rsp_sm    = r_sm;
  end

endmodule

// File: tb/tb_cmp_rr_arbiter.sv
// Directed bench for cmp_rr_arbiter: reset, compare results, round-robin order,
// back-pressure hold, operand capture, mid-response reset and boundary operands.
module tb_cmp_rr_arbiter;
  localparam int N_REQ = 4;
  localparam int W     = 4;
  localparam int ID_W  = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic [N_REQ-1:0]   req;
  logic [N_REQ*W-1:0] a_in, b_in;
  logic [N_REQ-1:0]   gnt;
  logic               busy, rsp_valid, rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic               rsp_eq, rsp_gt, rsp_sm;

  int n_chk  = 0;
  int n_pass = 0;

  cmp_rr_arbiter #(.N_REQ(N_REQ), .W(W)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .busy(busy), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_eq(rsp_eq), .rsp_gt(rsp_gt), .rsp_sm(rsp_sm)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic set_ops(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    a_in[i*W +: W] = a;
    b_in[i*W +: W] = b;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; rsp_ready = 1'b1;
    tick(); tick();
    rst = 1'b0;
  endtask

  // Flags as {eq,gt,sm}
  task automatic chk_flags(input string tag, input logic [2:0] exp);
    chk({tag, "_flags"}, {rsp_eq, rsp_gt, rsp_sm}, exp);
    chk({tag, "_one"}, int'(rsp_eq) + int'(rsp_gt) + int'(rsp_sm), 1);
  endtask

  // Single-requester operation with rsp_ready=1: grant, response, accept.
  task automatic do_op(input string tag, input int i, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [2:0] exp);
    set_ops(i, a, b);
    rsp_ready = 1'b1;
    req = N_REQ'(1) << i;
    tick();
    chk({tag, "_gnt"}, gnt, N_REQ'(1) << i);
    req = '0;
    tick();
    chk({tag, "_vld"}, rsp_valid, 1);
    chk({tag, "_id"}, rsp_id, i);
    chk_flags(tag, exp);
    tick();
    chk({tag, "_acc"}, rsp_valid, 0);
  endtask

  initial begin
    rst = 1'b1; req = '0; a_in = '0; b_in = '0; rsp_ready = 1'b1;
    do_reset();

    chk("rst_gnt", gnt, 0);
    chk("rst_busy", busy, 0);
    chk("rst_vld", rsp_valid, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_flags", {rsp_eq, rsp_gt, rsp_sm}, 3'b000);

    // Single request: 9 > 3, then ptr=1 and equal operands
    set_ops(0, 4'h9, 4'h3);
    req = 4'b0001;
    tick();
    chk("s1_gnt", gnt, 4'b0001);
    chk("s1_busy", busy, 1);
    req = '0;
    tick();
    chk("s1_gnt_pulse", gnt, 0);
    chk("s1_vld", rsp_valid, 1);
    chk("s1_id", rsp_id, 0);
    chk_flags("s1", 3'b010);
    tick();
    chk("s1_acc", rsp_valid, 0);
    chk("s1_idle", busy, 0);
    do_op("s2", 0, 4'h7, 4'h7, 3'b100);

    // Fairness from ptr=0 with all requesters held
    do_reset();
    for (int i = 0; i < N_REQ; i++) set_ops(i, W'(i), 4'h2);
    req = 4'b1111;
    for (int n = 0; n < 6; n++) begin
      tick();
      chk($sformatf("rr%0d_gnt", n), gnt, 4'b0001 << (n % 4));
      tick();
      chk($sformatf("rr%0d_gap", n), gnt, 0);
      chk($sformatf("rr%0d_id", n), rsp_id, n % 4);
      tick();
      chk($sformatf("rr%0d_acc", n), gnt, 0);
    end
    req = '0;
    tick();
    chk("rr_drain", busy, 0);

    // Back-pressure: ptr=2, requester 2 holds 0 < F
    set_ops(2, 4'h0, 4'hF);
    rsp_ready = 1'b0;
    req = 4'b0100;
    tick();
    chk("bp_gnt", gnt, 4'b0100);
    req = 4'b1011;
    tick();
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp%0d_vld", c), rsp_valid, 1);
      chk($sformatf("bp%0d_id", c), rsp_id, 2);
      chk($sformatf("bp%0d_sm", c), {rsp_eq, rsp_gt, rsp_sm}, 3'b001);
      chk($sformatf("bp%0d_busy", c), busy, 1);
      chk($sformatf("bp%0d_gnt", c), gnt, 0);
      if (c < 4) tick();
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_acc", rsp_valid, 0);
    tick();
    chk("bp_next_gnt", gnt, 4'b1000);
    req = '0;
    tick();
    chk("bp_next_id", rsp_id, 3);
    tick();

    // Operand capture: A1 changes after the grant
    set_ops(1, 4'hF, 4'h8);
    req = 4'b0010;
    tick();
    chk("cap_gnt", gnt, 4'b0010);
    set_ops(1, 4'h0, 4'h8);
    req = '0;
    tick();
    chk("cap_id", rsp_id, 1);
    chk_flags("cap", 3'b010);
    tick();

    // Reset while response is held
    set_ops(0, 4'h1, 4'h2);
    rsp_ready = 1'b0;
    req = 4'b0001;
    tick();
    req = '0;
    tick();
    chk("mr_vld_pre", rsp_valid, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mr_vld", rsp_valid, 0);
    chk("mr_busy", busy, 0);
    chk("mr_gnt", gnt, 0);
    rsp_ready = 1'b1;
    req = 4'b1000;
    tick();
    chk("mr_gnt3", gnt, 4'b1000);
    req = '0;
    tick();
    chk("mr_id3", rsp_id, 3);
    tick();

    // Boundary operands
    do_op("bF_F", 0, 4'hF, 4'hF, 3'b100);
    do_op("b0_0", 1, 4'h0, 4'h0, 3'b100);
    do_op("bF_0", 2, 4'hF, 4'h0, 3'b010);
    do_op("b0_F", 3, 4'h0, 4'hF, 3'b001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
